// File: rtl/rx_meta_tagger.sv
// Store-and-forward RX tagger: buffers MAC frames, discards bad or overflowed
// ones, and presents each good frame with its byte length and source port on tuser.
module rx_meta_tagger #(
  parameter int                     C_DATA_WIDTH  = 64,
  parameter int                     C_TUSER_WIDTH = 128,
  parameter int                     C_LEN_WIDTH   = 16,
  parameter int                     C_SPT_WIDTH   = 8,
  parameter int                     C_DPT_WIDTH   = 8,
  parameter logic [C_SPT_WIDTH-1:0] C_SRC_PORT    = 8'h01,
  parameter int                     C_DATA_DEPTH  = 512,
  parameter int                     C_META_DEPTH  = 16
) (
  input  logic                        axi_aclk,
  input  logic                        axi_reset,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_terr,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        drop_pulse,
  output logic [31:0]                 drop_count
);

  localparam int STRB_W  = C_DATA_WIDTH / 8;
  localparam int DAW     = $clog2(C_DATA_DEPTH);
  localparam int MAW     = $clog2(C_META_DEPTH);
  localparam int ENTRY_W = C_DATA_WIDTH + STRB_W + 1;
  localparam int PAD_W   = C_TUSER_WIDTH - C_DPT_WIDTH - C_SPT_WIDTH - C_LEN_WIDTH;

  function automatic logic [C_LEN_WIDTH-1:0] strb_bytes(input logic [STRB_W-1:0] s);
    logic [C_LEN_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) n = n + C_LEN_WIDTH'(s[i]);
    return n;
  endfunction

  typedef enum logic [1:0] {I_IDLE, I_RECV, I_DROP} in_state_t;
  typedef enum logic       {O_IDLE, O_SEND}         out_state_t;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic [ENTRY_W-1:0]     data_mem [C_DATA_DEPTH];
  logic [C_LEN_WIDTH-1:0] meta_mem [C_META_DEPTH];

  logic [DAW:0]             wr_ptr, cm_ptr, rd_ptr;
  logic [MAW:0]             mwr, mrd;
  logic [C_LEN_WIDTH-1:0]   len_acc, len_sum;
  logic                     beat, ovf, data_full, meta_full, meta_empty;
  logic                     wr_en, commit, drop, load, pop;
  logic [ENTRY_W-1:0]       rd_entry;
  logic [C_TUSER_WIDTH-1:0] tuser_word;

  assign s_axis_tready = ~axi_reset;
  assign beat          = s_axis_tvalid & s_axis_tready;
  // Full/empty use the extra wrap bit of each pointer.
  assign data_full  = (wr_ptr[DAW] != rd_ptr[DAW]) && (wr_ptr[DAW-1:0] == rd_ptr[DAW-1:0]);
  assign meta_full  = (mwr[MAW] != mrd[MAW]) && (mwr[MAW-1:0] == mrd[MAW-1:0]);
  assign meta_empty = (mwr == mrd);
  assign ovf        = beat & data_full;
  assign len_sum    = len_acc + strb_bytes(s_axis_tstrb);
  assign rd_entry   = data_mem[rd_ptr[DAW-1:0]];
  assign tuser_word = {{PAD_W{1'b0}}, {C_DPT_WIDTH{1'b0}}, C_SRC_PORT, meta_mem[mrd[MAW-1:0]]};

  // Input stage: speculative write, then commit or rewind on tlast
  always_comb begin
    in_next = in_state;
    wr_en   = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    if (beat) begin
      case (in_state)
        I_IDLE, I_RECV: begin
          wr_en = ~ovf;
          if (s_axis_tlast) begin
            if (ovf || s_axis_terr || meta_full) drop = 1'b1;
            else                                 commit = 1'b1;
            in_next = I_IDLE;
          end else if (ovf) begin
            in_next = I_DROP;
          end else begin
            in_next = I_RECV;
          end
        end
        I_DROP: begin
          if (s_axis_tlast) begin
            drop    = 1'b1;
            in_next = I_IDLE;
          end
        end
        default: in_next = I_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      in_state   <= I_IDLE;
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      mwr        <= '0;
      len_acc    <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      in_state <= in_next;
      if (drop)       wr_ptr <= cm_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (commit) begin
        cm_ptr <= wr_ptr + 1'b1;
        mwr    <= mwr + 1'b1;
      end
      if (beat) len_acc <= s_axis_tlast ? '0 : len_sum;
      drop_pulse <= drop;
      if (drop) drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (wr_en)  data_mem[wr_ptr[DAW-1:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (commit) meta_mem[mwr[MAW-1:0]]    <= len_sum;
  end

  // Output stage: one committed packet at a time from the meta FIFO head
  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    pop      = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (!meta_empty) begin
          out_next = O_SEND;
          load     = 1'b1;
        end
      end
      O_SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            pop      = 1'b1;
            out_next = O_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: out_next = O_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      out_state     <= O_IDLE;
      rd_ptr        <= '0;
      mrd           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      out_state <= out_next;
      if (load) begin
        {m_axis_tlast, m_axis_tstrb, m_axis_tdata} <= rd_entry;
        m_axis_tvalid <= 1'b1;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (load && out_state == O_IDLE) m_axis_tuser <= tuser_word;
      if (pop) begin
        m_axis_tvalid <= 1'b0;
        mrd           <= mrd + 1'b1;
      end
    end
  end

endmodule
